// File: rtl/game_pkg.sv
// Shared game definitions: state-generator codes, arrow codes, judge FSM states
// and the small BCD/LFSR helpers used by the judge and the display path.
package game_pkg;

    localparam logic [1:0] GS_GAME  = 2'd0;
    localparam logic [1:0] GS_PAUSE = 2'd1;
    localparam logic [1:0] GS_RESET = 2'd2;

    localparam logic [4:0] ARROW_FIRST = 5'd10;
    localparam logic [4:0] ARROW_NONE  = 5'd20;

    typedef enum logic [1:0] {
        J_IDLE,
        J_SHOW,
        J_HIT,
        J_MISS
    } judge_state_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Button mask order is {up, down, left, right}.
    function automatic logic [3:0] arrow_mask(input logic [4:0] code);
        logic [3:0] m;
        case (code)
            5'd10:   m = 4'b1000;
            5'd11:   m = 4'b0100;
            5'd12:   m = 4'b0010;
            5'd13:   m = 4'b0001;
            5'd14:   m = 4'b1100;
            5'd15:   m = 4'b1010;
            5'd16:   m = 4'b1001;
            5'd17:   m = 4'b0110;
            5'd18:   m = 4'b0101;
            5'd19:   m = 4'b0011;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] arrow_from_lfsr(input logic [5:0] lfsr);
        return ARROW_FIRST + 5'(lfsr % 6'd10);
    endfunction

    function automatic logic [5:0] lfsr_next(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.tens == 4'd9 && v.ones == 4'd9) begin
            r = v;
        end else if (v.ones == 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic logic bcd2_gt(input bcd2_t a, input bcd2_t b);
        return (a.tens > b.tens) || ((a.tens == b.tens) && (a.ones > b.ones));
    endfunction

endpackage

// File: rtl/arrow_judge_if.sv
// Game-side bundle of the arrow judge: state/tick/buttons in, arrow, feedback
// and BCD scores out. master = state generator side, slave = judge.
interface arrow_judge_if;

    logic [1:0] state;
    logic       game_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;

    logic [4:0] arrow;
    logic       hit;
    logic       miss;
    logic       combo_pulse;
    logic [3:0] combo_tens;
    logic [3:0] combo_ones;
    logic [3:0] best_tens;
    logic [3:0] best_ones;

    modport master (
        output state, game_tick, btn_up, btn_down, btn_left, btn_right,
        input  arrow, hit, miss, combo_pulse,
        input  combo_tens, combo_ones, best_tens, best_ones
    );

    modport slave (
        input  state, game_tick, btn_up, btn_down, btn_left, btn_right,
        output arrow, hit, miss, combo_pulse,
        output combo_tens, combo_ones, best_tens, best_ones
    );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter: increment saturating at 99, synchronous clear
// (priority over increment), asynchronous active-high reset.
module bcd2_counter
    import game_pkg::*;
(
    input  logic  clk,
    input  logic  Reset_press,
    input  logic  inc,
    input  logic  clr,
    output bcd2_t value,
    output bcd2_t value_inc
);

    bcd2_t count_q, count_d;

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = bcd2_inc(count_q);
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge Reset_press) begin
        if (Reset_press) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value     = count_q;
    assign value_inc = bcd2_inc(count_q);

endmodule

// File: rtl/arrow_judge.sv
// Arrow judge: shows one LFSR-chosen arrow at a time, judges button presses
// inside a tick window, and keeps a saturating BCD combo and best combo.
module arrow_judge
    import game_pkg::*;
#(
    parameter int unsigned WINDOW_TICKS   = 8,
    parameter int unsigned FEEDBACK_TICKS = 2,
    parameter logic [5:0]  LFSR_SEED      = 6'b101011
) (
    input logic           clk,
    input logic           Reset_press,
    arrow_judge_if.slave  bus
);

    localparam int unsigned TIMER_MAX = (WINDOW_TICKS > FEEDBACK_TICKS) ? WINDOW_TICKS : FEEDBACK_TICKS;
    localparam int          TW        = $clog2(TIMER_MAX + 1);

    judge_state_e fsm_q, fsm_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pressed_q, pressed_d;
    logic [4:0]    arrow_q, arrow_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          pulse_q, pulse_d;
    logic [5:0]    lfsr_q, lfsr_d;
    bcd2_t         best_q, best_d;

    logic [3:0] btn_mask;
    logic [3:0] required;
    logic       go_show, go_hit, go_miss;
    logic       combo_inc, combo_clr;
    bcd2_t      combo, combo_next;

    assign btn_mask = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
    assign required = arrow_mask(arrow_q);

    bcd2_counter u_combo (
        .clk         (clk),
        .Reset_press (Reset_press),
        .inc         (combo_inc),
        .clr         (combo_clr),
        .value       (combo),
        .value_inc   (combo_next)
    );

    always_comb begin
        fsm_d     = fsm_q;
        timer_d   = timer_q;
        pressed_d = pressed_q;
        arrow_d   = arrow_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        pulse_d   = 1'b0;
        lfsr_d    = lfsr_q;
        best_d    = best_q;
        go_show   = 1'b0;
        go_hit    = 1'b0;
        go_miss   = 1'b0;
        combo_inc = 1'b0;
        combo_clr = 1'b0;

        case (bus.state)
            GS_RESET: begin
                fsm_d     = J_IDLE;
                timer_d   = '0;
                pressed_d = '0;
                arrow_d   = ARROW_NONE;
                hit_d     = 1'b0;
                miss_d    = 1'b0;
                combo_clr = 1'b1;
            end
            GS_GAME: begin
                lfsr_d = lfsr_next(lfsr_q);
                unique case (fsm_q)
                    J_IDLE: go_show = bus.game_tick;
                    J_SHOW: begin
                        // Wrong press beats completion, completion beats the expiring tick.
                        pressed_d = pressed_q | btn_mask;
                        if ((btn_mask & ~required) != 4'b0000) begin
                            go_miss = 1'b1;
                        end else if ((pressed_q | btn_mask) == required) begin
                            go_hit = 1'b1;
                        end else if (bus.game_tick) begin
                            if (timer_q == TW'(1)) go_miss = 1'b1;
                            else                   timer_d = timer_q - TW'(1);
                        end
                    end
                    J_HIT, J_MISS: begin
                        if (bus.game_tick) begin
                            if (timer_q == TW'(1)) go_show = 1'b1;
                            else                   timer_d = timer_q - TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            GS_PAUSE: ;
            default: ;
        endcase

        if (go_show) begin
            fsm_d     = J_SHOW;
            arrow_d   = arrow_from_lfsr(lfsr_q);
            timer_d   = TW'(WINDOW_TICKS);
            pressed_d = '0;
            hit_d     = 1'b0;
            miss_d    = 1'b0;
        end
        if (go_hit) begin
            fsm_d     = J_HIT;
            arrow_d   = ARROW_NONE;
            timer_d   = TW'(FEEDBACK_TICKS);
            hit_d     = 1'b1;
            miss_d    = 1'b0;
            pulse_d   = 1'b1;
            combo_inc = 1'b1;
            if (bcd2_gt(combo_next, best_q)) best_d = combo_next;
        end
        if (go_miss) begin
            fsm_d     = J_MISS;
            arrow_d   = ARROW_NONE;
            timer_d   = TW'(FEEDBACK_TICKS);
            hit_d     = 1'b0;
            miss_d    = 1'b1;
            combo_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Reset_press) begin
        if (Reset_press) begin
            fsm_q     <= J_IDLE;
            timer_q   <= '0;
            pressed_q <= '0;
            arrow_q   <= ARROW_NONE;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            pulse_q   <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            best_q    <= '0;
        end else begin
            fsm_q     <= fsm_d;
            timer_q   <= timer_d;
            pressed_q <= pressed_d;
            arrow_q   <= arrow_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            pulse_q   <= pulse_d;
            lfsr_q    <= lfsr_d;
            best_q    <= best_d;
        end
    end

    assign bus.arrow       = arrow_q;
    assign bus.hit         = hit_q;
    assign bus.miss        = miss_q;
    assign bus.combo_pulse = pulse_q;
    assign bus.combo_tens  = combo.tens;
    assign bus.combo_ones  = combo.ones;
    assign bus.best_tens   = best_q.tens;
    assign bus.best_ones   = best_q.ones;

endmodule

// File: tb/tb_arrow_judge.sv
// Randomised and directed bench for arrow_judge against a behavioural game model
// (integer combo/best, phase + countdown, LFSR as integer arithmetic).
module tb_arrow_judge;

    localparam int WIN  = 8;
    localparam int FB   = 2;
    localparam int SEED = 43;

    logic clk = 1'b0;
    logic Reset_press;

    arrow_judge_if bus ();

    arrow_judge #(
        .WINDOW_TICKS   (WIN),
        .FEEDBACK_TICKS (FB),
        .LFSR_SEED      (6'b101011)
    ) dut (
        .clk         (clk),
        .Reset_press (Reset_press),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 arrow live, 2 hit feedback, 3 miss feedback.
    int mask_tab[10] = '{8, 4, 2, 1, 12, 10, 9, 6, 5, 3};
    int m_phase, m_arrow, m_timer, m_pressed, m_combo, m_best, m_lfsr, m_pulse;
    int pulse_seen = 0;

    function automatic int req_of(input int a);
        return mask_tab[a - 10];
    endfunction

    task automatic model_reset();
        m_phase = 0; m_arrow = 20; m_timer = 0; m_pressed = 0;
        m_combo = 0; m_best = 0; m_lfsr = SEED; m_pulse = 0;
    endtask

    task automatic m_start(input int seed_val);
        m_phase = 1; m_arrow = 10 + (seed_val % 10); m_timer = WIN; m_pressed = 0;
    endtask

    task automatic m_hit();
        m_combo = (m_combo < 99) ? m_combo + 1 : 99;
        if (m_combo > m_best) m_best = m_combo;
        m_pulse = 1; m_phase = 2; m_timer = FB;
    endtask

    task automatic m_miss();
        m_combo = 0; m_phase = 3; m_timer = FB;
    endtask

    task automatic model_step(input int st, input bit tk, input int b);
        int cur;
        int req;
        m_pulse = 0;
        if (st == 2) begin
            m_phase = 0; m_timer = 0; m_pressed = 0; m_combo = 0;
        end else if (st == 0) begin
            cur = m_lfsr;
            m_lfsr = ((m_lfsr << 1) & 63) | (((m_lfsr >> 5) ^ (m_lfsr >> 4)) & 1);
            case (m_phase)
                0: if (tk) m_start(cur);
                1: begin
                    req = req_of(m_arrow);
                    m_pressed = m_pressed | b;
                    if ((b & ~req) != 0) m_miss();
                    else if (m_pressed == req) m_hit();
                    else if (tk) begin
                        m_timer--;
                        if (m_timer == 0) m_miss();
                    end
                end
                default: if (tk) begin
                    m_timer--;
                    if (m_timer == 0) m_start(cur);
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("arrow", bus.arrow, (m_phase == 1) ? m_arrow : 20);
        check("hit", bus.hit, m_phase == 2);
        check("miss", bus.miss, m_phase == 3);
        check("combo_pulse", bus.combo_pulse, m_pulse);
        check("combo_tens", bus.combo_tens, m_combo / 10);
        check("combo_ones", bus.combo_ones, m_combo % 10);
        check("best_tens", bus.best_tens, m_best / 10);
        check("best_ones", bus.best_ones, m_best % 10);
        if (bus.combo_pulse === 1'b1) pulse_seen++;
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input int st, input bit tk, input int b);
        bus.state     = st[1:0];
        bus.game_tick = tk;
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b[3:0];
        if (Reset_press) model_reset();
        else             model_step(st, tk, b);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        bus.game_tick = 1'b0;
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
    endtask

    task automatic async_reset();
        Reset_press = 1'b1;
        #1;
        model_reset();
        compare_all();
        drive(0, 1'b1, 15);
        Reset_press = 1'b0;
    endtask

    task automatic reach_show();
        int n;
        n = 0;
        while (m_phase != 1 && n < 40) begin
            drive(0, 1'b1, 0);
            n++;
        end
        check("reach_show_live", (bus.arrow >= 5'd10) && (bus.arrow <= 5'd19), 1);
    endtask

    task automatic press_full();
        drive(0, 1'b0, req_of(m_arrow));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int req, first, second, wrong, saved, st, b, r;
        bit tk;

        Reset_press   = 1'b1;
        bus.state     = 2'd0;
        bus.game_tick = 1'b0;
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
        model_reset();
        @(negedge clk);
        compare_all();
        check("rst_arrow", bus.arrow, 20);
        Reset_press = 1'b0;

        // Reset asserted while an arrow is live.
        reach_show();
        drive(0, 1'b0, 0);
        async_reset();
        check("midshow_rst_arrow", bus.arrow, 20);
        check("midshow_rst_combo", {bus.combo_tens, bus.combo_ones}, 0);
        check("midshow_rst_best", {bus.best_tens, bus.best_ones}, 0);
        drive(0, 1'b1, 0);
        check("resume_arrow_live", (bus.arrow >= 5'd10) && (bus.arrow <= 5'd19), 1);

        // Hit, pairs pressed one button at a time.
        reach_show();
        req    = req_of(m_arrow);
        first  = req & (~(req - 1));
        second = req ^ first;
        if (second != 0) begin
            drive(0, 1'b0, first);
            check("partial_no_hit", bus.hit, 0);
            drive(0, 1'b0, 0);
            drive(0, 1'b0, 0);
            drive(0, 1'b0, second);
        end else begin
            drive(0, 1'b0, first);
        end
        check("hit_flag", bus.hit, 1);
        check("hit_pulse", bus.combo_pulse, 1);
        check("hit_combo", {bus.combo_tens, bus.combo_ones}, 8'h01);
        drive(0, 1'b0, 0);
        check("pulse_one_cycle", bus.combo_pulse, 0);
        drive(0, 1'b1, 0);
        check("fb_tick1_hold", bus.hit, 1);
        drive(0, 1'b1, 0);
        check("fb_next_arrow", (bus.arrow >= 5'd10) && (bus.arrow <= 5'd19), 1);

        // Wrong button after building combo 07.
        async_reset();
        repeat (7) begin
            reach_show();
            press_full();
        end
        reach_show();
        req = req_of(m_arrow);
        wrong = (~req) & 15;
        wrong = wrong & (~(wrong - 1));
        drive(0, 1'b0, wrong);
        check("wrong_miss", bus.miss, 1);
        check("wrong_combo", {bus.combo_tens, bus.combo_ones}, 8'h00);
        check("wrong_best", {bus.best_tens, bus.best_ones}, 8'h07);

        // Timeout on the window's last tick, then completion on that same tick.
        reach_show();
        repeat (WIN - 1) drive(0, 1'b1, 0);
        check("timeout_not_yet", bus.miss, 0);
        drive(0, 1'b1, 0);
        check("timeout_miss", bus.miss, 1);
        reach_show();
        repeat (WIN - 1) drive(0, 1'b1, 0);
        drive(0, 1'b1, req_of(m_arrow));
        check("last_tick_hit", bus.hit, 1);

        // Pause with three ticks left, then a one-cycle RESET state.
        reach_show();
        repeat (WIN - 3) drive(0, 1'b1, 0);
        saved = m_arrow;
        repeat (6) begin
            drive(($urandom_range(0, 1) == 0) ? 1 : 3, 1'b1, $urandom_range(0, 15));
            check("pause_arrow", bus.arrow, saved);
        end
        drive(0, 1'b1, 0);
        drive(0, 1'b1, 0);
        check("resume_tick2", bus.miss, 0);
        drive(0, 1'b1, 0);
        check("resume_tick3_miss", bus.miss, 1);
        saved = m_best;
        drive(2, 1'b1, 0);
        check("rstate_arrow", bus.arrow, 20);
        check("rstate_miss", bus.miss, 0);
        check("rstate_combo", {bus.combo_tens, bus.combo_ones}, 0);
        check("rstate_best", (bus.best_tens * 10) + bus.best_ones, saved);
        drive(0, 1'b1, 0);
        check("rstate_resume", (bus.arrow >= 5'd10) && (bus.arrow <= 5'd19), 1);

        // Random play.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            r  = $urandom_range(0, 19);
            st = (r < 14) ? 0 : (r < 17) ? 1 : (r < 18) ? 3 : 2;
            tk = ($urandom_range(0, 9) < 3);
            r  = $urandom_range(0, 9);
            if (r < 7) begin
                b = 0;
            end else if (r < 9 && m_phase == 1) begin
                b = req_of(m_arrow) & (1 << $urandom_range(0, 3));
                if (b == 0) b = req_of(m_arrow);
            end else begin
                b = $urandom_range(0, 15);
            end
            drive(st, tk, b);
        end

        // Saturation.
        pulse_seen = 0;
        repeat (100) begin
            reach_show();
            press_full();
        end
        check("sat_pulses", pulse_seen, 100);
        check("sat_combo", {bus.combo_tens, bus.combo_ones}, 8'h99);
        check("sat_best", {bus.best_tens, bus.best_ones}, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
